message_feeder: RTL

MESSAGE_FEEDER -- requirements
Module: message_feeder

---
 rtl/message_feeder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/message_feeder.sv
// Buffers upstream LFSR words in a small first-word-fall-through FIFO and hands
// a counted batch of them to the downstream DES core over a valid/ready link.
module message_feeder #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_messages,
    input  logic [63:0]        lfsr_in,
    input  logic               lfsr_valid,
    output logic [63:0]        msg_out,
    output logic               msg_valid,
    input  logic               msg_ready,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] issued_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]   OCC_ONE   = OCC_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [63:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [OCC_W-1:0]   occ_r;
    logic [COUNT_W-1:0] n_r;
    logic [COUNT_W-1:0] accepted_r;
    logic [COUNT_W-1:0] issued_r;
    logic               empty_s;
    logic               start_ok_s;
    logic               push_s;
    logic               pop_s;
    logic               last_pop_s;

    // Handshake qualifiers; fullness is judged on start-of-cycle occupancy, so no full bypass.
    always_comb begin
        empty_s    = (occ_r == {OCC_W{1'b0}});
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        push_s     = (state_r == ST_FILL) && lfsr_valid && (occ_r < DEPTH_OCC) && (accepted_r < n_r);
        pop_s      = !empty_s && msg_ready;
        last_pop_s = pop_s && ((issued_r + CNT_ONE) == n_r);
    end

    // Next-state logic for the batch sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    if (num_messages == {COUNT_W{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_FILL: begin
                if (last_pop_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Storage array; contents need no reset because the output is masked when empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= lfsr_in;
        end
    end

    // Pointers, occupancy and batch counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            occ_r      <= {OCC_W{1'b0}};
            n_r        <= {COUNT_W{1'b0}};
            accepted_r <= {COUNT_W{1'b0}};
            issued_r   <= {COUNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
            // FIFO is always empty when a start is honoured, so counters restart cleanly.
            if (start_ok_s) begin
                n_r        <= num_messages;
                accepted_r <= {COUNT_W{1'b0}};
                issued_r   <= {COUNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    accepted_r <= accepted_r + CNT_ONE;
                end
                if (pop_s) begin
                    issued_r <= issued_r + CNT_ONE;
                end
            end
        end
    end

    assign msg_valid    = !empty_s;
    assign msg_out      = empty_s ? 64'd0 : mem_r[rd_ptr_r];
    assign busy         = (state_r == ST_FILL);
    assign done         = (state_r == ST_DONE);
    assign issued_count = issued_r;

endmodule
